// File: rtl/gray_pkg.sv
// Shared helpers for Gray-code consumers: width-generic decode, single-bit
// change detection and the tracker FSM state type.
package gray_pkg;

    // Widest Gray value the helpers accept; narrower values are zero-extended.
    localparam int unsigned GRAY_MAX_W = 32;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } track_state_e;

    // Zero-extension is harmless: leading zero Gray bits decode to leading zeros.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic is_single_bit_diff(input logic [GRAY_MAX_W-1:0] a,
                                                input logic [GRAY_MAX_W-1:0] b);
        logic [GRAY_MAX_W-1:0] x;
        x = a ^ b;
        return (x != '0) && ((x & (x - GRAY_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchronizer for a Gray-coded bus, with a flag that rises once
// every stage has been refilled with real samples after reset.
module gray_sync
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             valid_o
);

    logic [WIDTH-1:0]  sync_q [STAGES];
    logic [STAGES-1:0] fill_q;

    // NOTE: this flop array is reset explicitly; it is a handful of flops,
    // not a RAM, and the reset value is part of the interface contract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
        end
    end

    assign q_o     = sync_q[STAGES-1];
    assign valid_o = fill_q[STAGES-1];

endmodule

// File: rtl/gray_to_binary_tracker.sv
// Receives a Gray count from another domain, decodes it to binary and
// classifies each change as a +1 step, a -1 step or an illegal jump.
module gray_to_binary_tracker
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] binary_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [GRAY_MAX_W-1:0] VAL_MASK = GRAY_MAX_W'((64'd1 << WIDTH) - 64'd1);

    logic [WIDTH-1:0] g_s;
    logic             sync_valid;

    gray_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (gray_in),
        .q_o     (g_s),
        .valid_o (sync_valid)
    );

    track_state_e     state_q, state_d;
    logic [WIDTH-1:0] g_prev_q, g_prev_d;
    logic [WIDTH-1:0] binary_q, binary_d;
    logic             valid_q, valid_d;
    logic             up_q, up_d;
    logic             dn_q, dn_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [GRAY_MAX_W-1:0] bin_cur;
    logic [GRAY_MAX_W-1:0] bin_prev;
    logic                  single_bit;
    logic                  is_inc;
    logic                  is_dec;

    assign bin_cur    = gray2bin(GRAY_MAX_W'(g_s));
    assign bin_prev   = gray2bin(GRAY_MAX_W'(g_prev_q));
    assign single_bit = is_single_bit_diff(GRAY_MAX_W'(g_s), GRAY_MAX_W'(g_prev_q));
    assign is_inc     = ((bin_prev + GRAY_MAX_W'(1)) & VAL_MASK) == bin_cur;
    assign is_dec     = ((bin_prev - GRAY_MAX_W'(1)) & VAL_MASK) == bin_cur;

    // NOTE: every next-state signal gets a default before the case so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        g_prev_d = g_prev_q;
        binary_d = binary_q;
        valid_d  = valid_q;
        up_d     = 1'b0;
        dn_d     = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            // Baseline waits until the synchronizer holds post-reset samples,
            // otherwise its reset zeros would be compared against real data.
            INIT: begin
                if (sync_valid) begin
                    g_prev_d = g_s;
                    binary_d = bin_cur[WIDTH-1:0];
                    valid_d  = 1'b1;
                    state_d  = TRACK;
                end
            end
            TRACK: begin
                g_prev_d = g_s;
                binary_d = bin_cur[WIDTH-1:0];
                if (g_s != g_prev_q) begin
                    // A one-bit change that is not an adjacent count means a
                    // sample was skipped, so it is treated as an error too.
                    if (single_bit && is_inc) begin
                        up_d = 1'b1;
                    end else if (single_bit && is_dec) begin
                        dn_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = err_d ? ERR_W'(1) : '0;
        end else if (err_d && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= INIT;
            g_prev_q  <= '0;
            binary_q  <= '0;
            valid_q   <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            g_prev_q  <= g_prev_d;
            binary_q  <= binary_d;
            valid_q   <= valid_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign binary_out = binary_q;
    assign bin_valid  = valid_q;
    assign step_up    = up_q;
    assign step_dn    = dn_q;
    assign step_err   = err_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed-vector bench for gray_to_binary_tracker at default parameters.
module tb_gray_to_binary_tracker;

    logic       clk;
    logic       rst_n;
    logic [3:0] gray_in;
    logic       err_clr;
    logic [3:0] binary_out;
    logic       bin_valid;
    logic       step_up;
    logic       step_dn;
    logic       step_err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    gray_to_binary_tracker #(
        .WIDTH       (4),
        .SYNC_STAGES (2),
        .ERR_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .err_clr    (err_clr),
        .binary_out (binary_out),
        .bin_valid  (bin_valid),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .step_err   (step_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset with a given Gray input, release, and wait until the baseline is loaded.
    task automatic do_reset(input logic [3:0] g);
        rst_n   = 1'b0;
        gray_in = g;
        err_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        gray_in = 4'b0110;
        err_clr = 1'b0;
        tick(2);
        total++;
        if ({binary_out, bin_valid, step_up, step_dn, step_err, err_count} !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: got bo=%b v=%b up=%b dn=%b err=%b cnt=%0d, want all 0",
                     binary_out, bin_valid, step_up, step_dn, step_err, err_count);
        end
        rst_n = 1'b1;
        tick(2);
        total++;
        if (bin_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid_early: got %b want 0 after 2 edges", bin_valid);
        end
        tick(1);
        total++;
        if (binary_out !== 4'b0100 || bin_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_baseline: got bo=%b v=%b want bo=0100 v=1", binary_out, bin_valid);
        end
        total++;
        if ({step_up, step_dn, step_err} !== 3'b000) begin
            bad++;
            $display("FAIL reset_no_pulse: got up/dn/err=%b want 000", {step_up, step_dn, step_err});
        end
        tick(2);
        total++;
        if ({step_up, step_dn, step_err} !== 3'b000 || binary_out !== 4'b0100) begin
            bad++;
            $display("FAIL reset_settled: got bo=%b pulses=%b want 0100/000",
                     binary_out, {step_up, step_dn, step_err});
        end
    endtask

    task automatic test_up_sequence;
        logic [3:0] gseq [16];
        logic [3:0] bexp [16];
        int         ups;
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        bexp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0};
        ups = 0;
        do_reset(4'b0000);
        total++;
        if (binary_out !== 4'd0 || bin_valid !== 1'b1) begin
            bad++;
            $display("FAIL up_baseline: got bo=%0d v=%b want 0/1", binary_out, bin_valid);
        end
        for (int i = 0; i < 16; i++) begin
            gray_in = gseq[i];
            for (int t = 1; t <= 5; t++) begin
                tick(1);
                if (step_up === 1'b1) ups++;
                total++;
                if (step_err !== 1'b0 || step_dn !== 1'b0 || step_up !== (t == 3)) begin
                    bad++;
                    $display("FAIL up_pulse[%0d.%0d]: got up=%b dn=%b err=%b want up=%b dn=0 err=0",
                             i, t, step_up, step_dn, step_err, (t == 3));
                end
                if (t == 3) begin
                    total++;
                    if (binary_out !== bexp[i]) begin
                        bad++;
                        $display("FAIL up_value[%0d]: got %0d want %0d", i, binary_out, bexp[i]);
                    end
                end
            end
        end
        total++;
        if (ups !== 16 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL up_totals: got ups=%0d errs=%0d want 16/0", ups, err_count);
        end
    endtask

    task automatic test_down;
        gray_in = 4'b1000;
        tick(3);
        total++;
        if (binary_out !== 4'd15 || step_dn !== 1'b1 || step_up !== 1'b0 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL down_wrap: got bo=%0d dn=%b up=%b err=%b want 15/1/0/0",
                     binary_out, step_dn, step_up, step_err);
        end
        tick(1);
        total++;
        if (step_dn !== 1'b0) begin
            bad++;
            $display("FAIL down_width: got dn=%b want 0", step_dn);
        end
        tick(1);
        gray_in = 4'b1001;
        tick(3);
        total++;
        if (binary_out !== 4'd14 || step_dn !== 1'b1 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL down_step: got bo=%0d dn=%b err=%b want 14/1/0", binary_out, step_dn, step_err);
        end
        tick(1);
        total++;
        if (step_dn !== 1'b0) begin
            bad++;
            $display("FAIL down_width2: got dn=%b want 0", step_dn);
        end
    endtask

    task automatic test_error;
        do_reset(4'b0001);
        total++;
        if (binary_out !== 4'd1 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL err_baseline: got bo=%0d cnt=%0d want 1/0", binary_out, err_count);
        end
        gray_in = 4'b0111;
        tick(3);
        total++;
        if (step_err !== 1'b1 || step_up !== 1'b0 || step_dn !== 1'b0 ||
            err_count !== 8'd1 || binary_out !== 4'b0101) begin
            bad++;
            $display("FAIL err_jump: got err=%b up=%b dn=%b cnt=%0d bo=%b want 1/0/0/1/0101",
                     step_err, step_up, step_dn, err_count, binary_out);
        end
        tick(1);
        total++;
        if (step_err !== 1'b0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL err_width: got err=%b cnt=%0d want 0/1", step_err, err_count);
        end
    endtask

    task automatic test_err_clr;
        gray_in = 4'b0000;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        total++;
        if (step_err !== 1'b1 || err_count !== 8'd1 || binary_out !== 4'd0) begin
            bad++;
            $display("FAIL clr_with_err: got err=%b cnt=%0d bo=%0d want 1/1/0",
                     step_err, err_count, binary_out);
        end
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL clr_alone: got cnt=%0d want 0", err_count);
        end
    endtask

    task automatic test_back_to_back;
        gray_in = 4'b0001;
        tick(1);
        gray_in = 4'b0011;
        tick(1);
        gray_in = 4'b0010;
        tick(1);
        total++;
        if (binary_out !== 4'd1 || step_up !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got bo=%0d up=%b want 1/1", binary_out, step_up);
        end
        tick(1);
        total++;
        if (binary_out !== 4'd2 || step_up !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got bo=%0d up=%b want 2/1", binary_out, step_up);
        end
        tick(1);
        total++;
        if (binary_out !== 4'd3 || step_up !== 1'b1 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_third: got bo=%0d up=%b err=%b want 3/1/0", binary_out, step_up, step_err);
        end
        tick(1);
        total++;
        if (step_up !== 1'b0 || binary_out !== 4'd3) begin
            bad++;
            $display("FAIL b2b_end: got bo=%0d up=%b want 3/0", binary_out, step_up);
        end
    endtask

    task automatic test_saturation;
        for (int k = 0; k < 300; k++) begin
            gray_in = (k % 2 == 0) ? 4'b0101 : 4'b0010;
            tick(1);
        end
        tick(3);
        total++;
        if (err_count !== 8'd255 || step_err !== 1'b0) begin
            bad++;
            $display("FAIL sat_hold: got cnt=%0d err=%b want 255/0", err_count, step_err);
        end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL sat_clear: got cnt=%0d want 0", err_count);
        end
    endtask

    task automatic test_mid_reset;
        do_reset(4'b1100);
        gray_in = 4'b1101;
        tick(3);
        total++;
        if (binary_out !== 4'd9 || step_up !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got bo=%0d up=%b want 9/1", binary_out, step_up);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({binary_out, bin_valid, step_up, step_dn, step_err, err_count} !== 16'h0) begin
            bad++;
            $display("FAIL mid_async_clear: got bo=%0d v=%b up=%b dn=%b err=%b cnt=%0d want all 0",
                     binary_out, bin_valid, step_up, step_dn, step_err, err_count);
        end
        gray_in = 4'b1010;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        total++;
        if (binary_out !== 4'd12 || bin_valid !== 1'b1 || step_err !== 1'b0 ||
            step_up !== 1'b0 || step_dn !== 1'b0) begin
            bad++;
            $display("FAIL mid_rebaseline: got bo=%0d v=%b err=%b up=%b dn=%b want 12/1/0/0/0",
                     binary_out, bin_valid, step_err, step_up, step_dn);
        end
        tick(3);
        total++;
        if (step_err !== 1'b0 || err_count !== 8'd0 || binary_out !== 4'd12) begin
            bad++;
            $display("FAIL mid_quiet: got err=%b cnt=%0d bo=%0d want 0/0/12", step_err, err_count, binary_out);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        gray_in = 4'b0000;
        err_clr = 1'b0;
        test_reset();
        test_up_sequence();
        test_down();
        test_error();
        test_err_clr();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
